// File: rtl/noc_txn_latency_tracker_if.sv
// Agent-side request/response channels observed by the latency tracker.
// The agent drives them (master); the tracker only samples them (slave).
interface noc_txn_latency_tracker_if #(
    parameter int ID_W = 4
);
    logic            rd_req_valid;
    logic [ID_W-1:0] rd_req_id;
    logic            rd_rsp_valid;
    logic [ID_W-1:0] rd_rsp_id;
    logic            wr_req_valid;
    logic [ID_W-1:0] wr_req_id;
    logic            wr_rsp_valid;
    logic [ID_W-1:0] wr_rsp_id;

    modport master (
        output rd_req_valid, rd_req_id, rd_rsp_valid, rd_rsp_id,
        output wr_req_valid, wr_req_id, wr_rsp_valid, wr_rsp_id
    );

    modport slave (
        input rd_req_valid, rd_req_id, rd_rsp_valid, rd_rsp_id,
        input wr_req_valid, wr_req_id, wr_rsp_valid, wr_rsp_id
    );
endinterface

// File: rtl/noc_txn_latency_tracker.sv
// Per-ID read/write latency, windowed completed-byte bandwidth and outstanding-entry
// occupancy for the NOC design monitor.
module noc_txn_latency_tracker #(
    parameter int          ID_W           = 4,
    parameter int          WINDOW         = 1024,
    parameter int          BYTES_PER_BEAT = 4,
    parameter logic [31:0] TS_INIT        = 32'd0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    noc_txn_latency_tracker_if.slave    bus,
    output logic [31:0]                 rd_latency,
    output logic [31:0]                 wr_latency,
    output logic                        rd_lat_upd,
    output logic                        wr_lat_upd,
    output logic [31:0]                 measured_bandwidth,
    output logic                        window_done,
    output logic [7:0]                  buffer_occupancy,
    output logic                        err_dup_id,
    output logic                        err_orphan_rsp
);
    localparam int                DEPTH    = 1 << ID_W;
    localparam int                WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);

    logic [31:0]      ts_q, ts_d;
    logic [DEPTH-1:0] rd_vld_q, rd_vld_d;
    logic [DEPTH-1:0] wr_vld_q, wr_vld_d;
    logic [31:0]      rd_ts_q [DEPTH];
    logic [31:0]      rd_ts_d [DEPTH];
    logic [31:0]      wr_ts_q [DEPTH];
    logic [31:0]      wr_ts_d [DEPTH];
    logic [WIN_W-1:0] win_q, win_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      bw_q, bw_d;
    logic [31:0]      rd_lat_q, rd_lat_d;
    logic [31:0]      wr_lat_q, wr_lat_d;
    logic             rd_upd_q, rd_upd_d;
    logic             wr_upd_q, wr_upd_d;
    logic             done_q, done_d;
    logic             dup_q, dup_d;
    logic             orph_q, orph_d;
    logic [7:0]       occ_q, occ_d;

    logic             rd_match, rd_orph, rd_dup;
    logic             wr_match, wr_orph, wr_dup;
    logic [31:0]      bytes;
    logic [31:0]      occ_cnt;

    always_comb begin
        ts_d     = ts_q + 32'd1;
        rd_vld_d = rd_vld_q;
        rd_ts_d  = rd_ts_q;
        rd_lat_d = rd_lat_q;
        wr_vld_d = wr_vld_q;
        wr_ts_d  = wr_ts_q;
        wr_lat_d = wr_lat_q;

        // Response retires against the old entry first, so a same-cycle request may reuse the slot.
        rd_match = bus.rd_rsp_valid && rd_vld_q[bus.rd_rsp_id];
        rd_orph  = bus.rd_rsp_valid && !rd_vld_q[bus.rd_rsp_id];
        if (rd_match) begin
            rd_vld_d[bus.rd_rsp_id] = 1'b0;
            rd_lat_d                = ts_q - rd_ts_q[bus.rd_rsp_id];
        end
        rd_dup = bus.rd_req_valid && rd_vld_d[bus.rd_req_id];
        if (bus.rd_req_valid && !rd_vld_d[bus.rd_req_id]) begin
            rd_vld_d[bus.rd_req_id] = 1'b1;
            rd_ts_d[bus.rd_req_id]  = ts_q;
        end

        wr_match = bus.wr_rsp_valid && wr_vld_q[bus.wr_rsp_id];
        wr_orph  = bus.wr_rsp_valid && !wr_vld_q[bus.wr_rsp_id];
        if (wr_match) begin
            wr_vld_d[bus.wr_rsp_id] = 1'b0;
            wr_lat_d                = ts_q - wr_ts_q[bus.wr_rsp_id];
        end
        wr_dup = bus.wr_req_valid && wr_vld_d[bus.wr_req_id];
        if (bus.wr_req_valid && !wr_vld_d[bus.wr_req_id]) begin
            wr_vld_d[bus.wr_req_id] = 1'b1;
            wr_ts_d[bus.wr_req_id]  = ts_q;
        end

        rd_upd_d = rd_match;
        wr_upd_d = wr_match;
        dup_d    = rd_dup || wr_dup;
        orph_d   = rd_orph || wr_orph;

        bytes = (32'(rd_match) + 32'(wr_match)) * 32'(BYTES_PER_BEAT);
        if (win_q == WIN_LAST) begin
            win_d  = '0;
            acc_d  = 32'd0;
            bw_d   = acc_q + bytes;
            done_d = 1'b1;
        end else begin
            win_d  = win_q + 1'b1;
            acc_d  = acc_q + bytes;
            bw_d   = bw_q;
            done_d = 1'b0;
        end

        occ_cnt = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + 32'(rd_vld_d[i]) + 32'(wr_vld_d[i]);
        end
        occ_d = (occ_cnt > 32'd255) ? 8'hFF : occ_cnt[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= TS_INIT;
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            rd_ts_q  <= '{default: '0};
            wr_ts_q  <= '{default: '0};
            win_q    <= '0;
            acc_q    <= 32'd0;
            bw_q     <= 32'd0;
            rd_lat_q <= 32'd0;
            wr_lat_q <= 32'd0;
            rd_upd_q <= 1'b0;
            wr_upd_q <= 1'b0;
            done_q   <= 1'b0;
            dup_q    <= 1'b0;
            orph_q   <= 1'b0;
            occ_q    <= 8'd0;
        end else begin
            ts_q     <= ts_d;
            rd_vld_q <= rd_vld_d;
            wr_vld_q <= wr_vld_d;
            rd_ts_q  <= rd_ts_d;
            wr_ts_q  <= wr_ts_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            bw_q     <= bw_d;
            rd_lat_q <= rd_lat_d;
            wr_lat_q <= wr_lat_d;
            rd_upd_q <= rd_upd_d;
            wr_upd_q <= wr_upd_d;
            done_q   <= done_d;
            dup_q    <= dup_d;
            orph_q   <= orph_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_latency         = rd_lat_q;
    assign wr_latency         = wr_lat_q;
    assign rd_lat_upd         = rd_upd_q;
    assign wr_lat_upd         = wr_upd_q;
    assign measured_bandwidth = bw_q;
    assign window_done        = done_q;
    assign buffer_occupancy   = occ_q;
    assign err_dup_id         = dup_q;
    assign err_orphan_rsp     = orph_q;
endmodule
